md5_block: RTL and testbench

Iterative, parameterised MD5 compression engine. It accepts one 512-bit padded message block over a valid/ready handshake and runs the 64 RFC 1321 steps over several clocks, with a configurable number of steps per clock. It adds the chaining variables and returns a 128-bit digest over a second valid/ready handshake. It sits between the upstream padding/word-assembly logic and the digest consumer, and supersedes the single-step combinational core as the top-level hashing unit.

---
 rtl/md5_pkg.sv | 78 +++++++
 rtl/md5_block_if.sv | 23 ++
 rtl/md5_step.sv | 34 +++
 rtl/md5_block.sv | 135 +++++++++++++
 tb/tb_md5_block.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_pkg.sv
// md5_pkg: constants, tables and helpers shared by the MD5 compression engine.
// Holds the IV, the T[] and shift tables, round encoding, message index and state encoding.
package md5_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 128;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  // Packed in digest order: A in the low word, D in the high word.
  localparam logic [127:0] IV_VEC = {IV_D, IV_C, IV_B, IV_A};

  typedef logic [1:0] round_t;
  localparam round_t ROUND_F = 2'd0;
  localparam round_t ROUND_G = 2'd1;
  localparam round_t ROUND_H = 2'd2;
  localparam round_t ROUND_I = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FINAL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [31:0] T_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amounts repeat every four steps within a round.
  localparam logic [4:0] S_TABLE [4][4] = '{
    '{5'd7, 5'd12, 5'd17, 5'd22},
    '{5'd5, 5'd9,  5'd14, 5'd20},
    '{5'd4, 5'd11, 5'd16, 5'd23},
    '{5'd6, 5'd10, 5'd15, 5'd21}
  };

  function automatic logic [4:0] shift_amt(logic [5:0] i);
    return S_TABLE[i[5:4]][i[1:0]];
  endfunction

  function automatic logic [3:0] msg_index(logic [5:0] i);
    logic [3:0] n;
    logic [3:0] g;
    n = i[3:0];
    g = n;
    case (i[5:4])
      ROUND_G: g = 4'(5 * n + 1);
      ROUND_H: g = 4'(3 * n + 5);
      ROUND_I: g = 4'(7 * n);
      default: g = n;
    endcase
    return g;
  endfunction

  function automatic logic [127:0] add_words(logic [127:0] x, logic [127:0] y);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = x[32*w +: 32] + y[32*w +: 32];
    return r;
  endfunction

endpackage

// File: rtl/md5_block_if.sv
// md5_block_if: block-in / digest-out handshakes of the MD5 engine.
interface md5_block_if;
  import md5_pkg::*;

  logic                in_valid_i;
  logic                in_ready_o;
  logic                first_i;
  logic [BLOCK_W-1:0]  blk_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [DIGEST_W-1:0] digest_o;
  logic                busy_o;

  modport master (
    output in_valid_i, first_i, blk_i, out_ready_i,
    input  in_ready_o, out_valid_o, digest_o, busy_o
  );

  modport slave (
    input  in_valid_i, first_i, blk_i, out_ready_i,
    output in_ready_o, out_valid_o, digest_o, busy_o
  );
endinterface

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step producing the new B word.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  round_t      round,
  input  logic [31:0] m,
  input  logic [4:0]  s,
  input  logic [31:0] t,
  output logic [31:0] new_b
);
  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;

  always_comb begin
    // NOTE: f gets a default before the case so no path leaves it unassigned (no latch).
    f = b ^ c ^ d;
    case (round)
      ROUND_F: f = (b & c) | (~b & d);
      ROUND_G: f = (b & d) | (c & ~d);
      ROUND_I: f = c ^ (b | ~d);
      default: f = b ^ c ^ d;
    endcase
  end

  assign sum   = a + f + m + t;
  // s is never zero, so the right shift is always less than 32.
  assign rot   = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
  assign new_b = b + rot;
endmodule

// File: rtl/md5_block.sv
// md5_block: iterative MD5 compression engine evaluating STEPS_PER_CYCLE steps per clock.
// Define MD5_CHAIN_EN to keep a chaining register and honour first_i for multi-block messages.
module md5_block
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic        clk_i,
  input logic        rst_i,
  md5_block_if.slave bus
);
  localparam int         S         = STEPS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(64 - S);
  localparam logic [5:0] STEP_INC  = 6'(S);

  if (S != 1 && S != 2 && S != 4 && S != 8 && S != 16) begin : g_bad_steps
    $error("md5_block: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t       state_q;
  logic [5:0]   step_q;
  logic [31:0]  msg_q [16];
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [127:0] digest_q;
  logic         out_valid_q;
  logic [127:0] h_start;
  logic [127:0] h_final;
  logic [127:0] load_val;
  logic         accept;

  assign accept = (state_q == ST_IDLE) && bus.in_valid_i;

`ifdef MD5_CHAIN_EN
  logic [127:0] h_q;
  // h_q is reloaded with the IV on a first block, so it always equals the start value.
  assign h_start  = h_q;
  assign load_val = bus.first_i ? IV_VEC : h_q;
`else
  logic unused_first;
  assign unused_first = bus.first_i;
  assign h_start      = IV_VEC;
  assign load_val     = IV_VEC;
`endif

  assign h_final = add_words(h_start, {d_q, c_q, b_q, a_q});

  // Step chain: element k holds the working registers before step step_q + k.
  logic [31:0] ca [S+1];
  logic [31:0] cb [S+1];
  logic [31:0] cc [S+1];
  logic [31:0] cd [S+1];

  assign ca[0] = a_q;
  assign cb[0] = b_q;
  assign cc[0] = c_q;
  assign cd[0] = d_q;

  for (genvar k = 0; k < S; k++) begin : g_step
    logic [5:0]  idx;
    logic [31:0] nb;
    assign idx = step_q + 6'(k);
    md5_step u_step (
      .a     (ca[k]),
      .b     (cb[k]),
      .c     (cc[k]),
      .d     (cd[k]),
      .round (idx[5:4]),
      .m     (msg_q[msg_index(idx)]),
      .s     (shift_amt(idx)),
      .t     (T_TABLE[idx]),
      .new_b (nb)
    );
    assign ca[k+1] = cd[k];
    assign cb[k+1] = nb;
    assign cc[k+1] = cb[k];
    assign cd[k+1] = cc[k];
  end

  // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid_i) begin
          step_q  <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          step_q <= step_q + STEP_INC;
          if (step_q == LAST_STEP) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          digest_q    <= h_final;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready_i) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MD5_CHAIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      h_q <= IV_VEC;
    else if (accept && bus.first_i) h_q <= IV_VEC;
    else if (state_q == ST_FINAL)   h_q <= h_final;
  end
`endif

  // NOTE: message and working registers have no reset; accept always loads them before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int j = 0; j < 16; j++) msg_q[j] <= bus.blk_i[32*j +: 32];
      {d_q, c_q, b_q, a_q} <= load_val;
    end else if (state_q == ST_RUN) begin
      a_q <= ca[S];
      b_q <= cb[S];
      c_q <= cc[S];
      d_q <= cd[S];
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.digest_o    = digest_q;
  assign bus.busy_o      = (state_q == ST_RUN) || (state_q == ST_FINAL);
endmodule

// File: tb/tb_md5_block.sv
// tb_md5_block: five engines (1,2,4,8,16 steps/clock) share stimulus; a scoreboard checks each
// digest and its latency against a textbook MD5 model.
module tb_md5_block;

  localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
`ifdef MD5_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         first = 1'b0;
  logic [511:0] blk = '0;
  logic         out_ready = 1'b1;

  logic [4:0]   rdy, vld, bsy;
  logic [127:0] dig [5];

  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  typedef struct {
    logic [127:0] digest;
    longint       acc;
  } exp_t;

  exp_t         exp_q[$];
  int           rd [5];
  logic [127:0] model_h = IV;
  logic [31:0]  t_tab [64];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    md5_block_if bus ();
    assign bus.in_valid_i  = in_valid;
    assign bus.first_i     = first;
    assign bus.blk_i       = blk;
    assign bus.out_ready_i = out_ready;
    assign rdy[k]          = bus.in_ready_o;
    assign vld[k]          = bus.out_valid_o;
    assign bsy[k]          = bus.busy_o;
    assign dig[k]          = bus.digest_o;
    md5_block #(.STEPS_PER_CYCLE(1 << k)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference MD5 compression straight from the algorithm description.
  function automatic logic [127:0] md5_model(input logic [127:0] hin, input logic [511:0] b512);
    int unsigned sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    int unsigned m [16];
    int unsigned a, b, c, d, f, tmp, x, s;
    int g;
    for (int j = 0; j < 16; j++) m[j] = b512[32*j +: 32];
    a = hin[31:0]; b = hin[63:32]; c = hin[95:64]; d = hin[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s   = sh[(i / 16) * 4 + (i % 4)];
      x   = a + f + t_tab[i] + m[g];
      tmp = d;
      d   = c;
      c   = b;
      b   = b + ((x << s) | (x >> (32 - s)));
      a   = tmp;
    end
    return {d + hin[127:96], c + hin[95:64], b + hin[63:32], a + hin[31:0]};
  endfunction

  function automatic logic [127:0] model_exp(input logic [511:0] b512, input logic f1);
    return md5_model((f1 || !CHAIN) ? IV : model_h, b512);
  endfunction

  // Turns a digest written as an RFC hex string into the byte order of digest_o.
  function automatic logic [127:0] from_hex(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127-8*k -: 8];
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #2;
    while (rdy !== 5'h1f && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (rdy !== 5'h1f) check("idle_timeout", 128'(rdy), 128'h1f);
  endtask

  task automatic issue(input logic [511:0] b512, input logic f1, input logic [127:0] exp);
    exp_t e;
    wait_idle();
    blk      = b512;
    first    = f1;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    e.digest = exp;
    e.acc    = cyc;
    exp_q.push_back(e);
    model_h  = exp;
  endtask

  task automatic monitor();
    logic [4:0] prev = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (vld[k]) begin
          if (rd[k] >= exp_q.size()) begin
            check($sformatf("spurious_out_s%0d", 1 << k), 128'(vld[k]), 128'h0);
          end else begin
            e = exp_q[rd[k]];
            check($sformatf("digest_s%0d_blk%0d", 1 << k, rd[k]), dig[k], e.digest);
            if (!prev[k])
              check($sformatf("latency_s%0d_blk%0d", 1 << k, rd[k]),
                    128'(cyc - e.acc), 128'((64 >> k) + 1));
            if (out_ready) rd[k]++;
          end
        end
        prev[k] = vld[k];
      end
    end
  endtask

  initial begin
    logic [511:0] b_empty, b_abc, b_a1, b_a2, b_rand;
    logic [127:0] abc_dig;
    int n;

    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      t_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    for (int k = 0; k < 5; k++) rd[k] = 0;

    b_empty = '0; b_empty[31:0] = 32'h00000080;
    b_abc   = '0; b_abc[31:0] = 32'h80636261; b_abc[14*32 +: 32] = 32'h18;
    for (int j = 0; j < 16; j++) b_a1[32*j +: 32] = 32'h61616161;
    b_a2    = '0; b_a2[31:0] = 32'h80; b_a2[14*32 +: 32] = 32'h200;
    abc_dig = from_hex(128'h900150983cd24fb0d6963f7d28e17f72);

    fork monitor(); join_none

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 128'(rdy), 128'h1f);
    check("rst_out_valid", 128'(vld), 128'h0);
    check("rst_busy", 128'(bsy), 128'h0);
    for (int k = 0; k < 5; k++) check($sformatf("rst_digest_s%0d", 1 << k), dig[k], 128'h0);
    rst = 1'b0;

    // Known-answer vectors.
    issue(b_empty, 1'b1, from_hex(128'hd41d8cd98f00b204e9800998ecf8427e));
    issue(b_abc, 1'b1, abc_dig);
    issue(b_a1, 1'b1, model_exp(b_a1, 1'b1));
    if (CHAIN) issue(b_a2, 1'b0, from_hex(128'h014842d480b571495a4a0363793f7367));
    else       issue(b_a2, 1'b0, model_exp(b_a2, 1'b0));

    // Back-pressure: hold the digest for 20 cycles and ignore an input pulse.
    wait_idle();
    out_ready = 1'b0;
    issue(b_abc, 1'b1, abc_dig);
    n = 0;
    while (vld !== 5'h1f && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("stall_all_valid", 128'(vld), 128'h1f);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        blk      = {16{$urandom()}};
        first    = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #2;
      check($sformatf("stall_in_ready_c%0d", c), 128'(rdy), 128'h0);
      check($sformatf("stall_busy_c%0d", c), 128'(bsy), 128'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 128'(rdy), 128'h1f);

    // Reset in the middle of a block aborts it everywhere.
    issue(b_abc, 1'b1, abc_dig);
    repeat (30) @(posedge clk);
    #2;
    check("mid_busy_s1", 128'(bsy[0]), 128'h1);
    rst = 1'b1;
    #1;
    check("abort_in_ready", 128'(rdy), 128'h1f);
    check("abort_out_valid", 128'(vld), 128'h0);
    check("abort_busy", 128'(bsy), 128'h0);
    for (int k = 0; k < 5; k++) check($sformatf("abort_digest_s%0d", 1 << k), dig[k], 128'h0);
    for (int k = 0; k < 5; k++) rd[k] = exp_q.size();
    model_h = IV;
    @(posedge clk); #2;
    rst = 1'b0;
    issue(b_abc, 1'b1, abc_dig);

    // Random blocks with random chaining.
    for (int b = 0; b < 100; b++) begin
      logic f1;
      for (int j = 0; j < 16; j++) b_rand[32*j +: 32] = $urandom();
      f1 = 1'($urandom_range(0, 1));
      issue(b_rand, f1, model_exp(b_rand, f1));
    end

    wait_idle();
    repeat (2) @(posedge clk);
    for (int k = 0; k < 5; k++)
      check($sformatf("drain_s%0d", 1 << k), 128'(rd[k]), 128'(exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
